pedestal_recovery_filter_bank: RTL and testbench
================================================

Name: pedestal_recovery_filter_bank

Overview:
Parametrised successor to the fixed 5x8 HPF/pedestal-recovery stage in the AFE readout path; sits between AFE deserialisation and the self-trigger/stream logic.
Each filtered lane:
- tracks a pedestal with a shift-based low-pass estimator;
- high-pass filters the pedestal-subtracted sample with a runtime-loadable first-order IIR;
- adds the pedestal back and saturates.
Coefficients are loaded over a valid/ready config port into shadow registers and committed atomically, replacing hard-coded values.

Parameters:
NUM_AFE, 5, number of AFE groups
NUM_CH, 8, filtered lanes per AFE; each group also carries one unfiltered pass-through lane (index NUM_CH)
DATA_W, 16, signed sample width
COEF_W, 18, signed coefficient width
FRAC_W, 15, coefficient fractional bits (1.0 = 2^FRAC_W)

Ports:
clk  in  1  sample clock, one sample per cycle
reset  in  1  asynchronous, active-high reset
en  in  1  filter advance enable
x  in  NUM_AFE*(NUM_CH+1)*DATA_W  input lanes; lane L = a*(NUM_CH+1)+c occupies bits [L*DATA_W +: DATA_W]
y  out  NUM_AFE*(NUM_CH+1)*DATA_W  output lanes, same packing
cfg_valid  in  1  config write strobe
cfg_ready  out  1  config accept
cfg_sel  in  3  0=b0, 1=b1, 2=a1, 3=lpf_shift, 4=commit, 5-7 ignored but accepted
cfg_data  in  COEF_W  write data (lpf_shift uses bits [3:0])
busy  out  1  high in INIT

Behaviour:
- Reset values: y=0, busy=1, state=INIT.
  - Shadow and active registers reset to b0=2^FRAC_W, b1=0, a1=0, lpf_shift=0, i.e. identity filter with pedestal disabled.
  - All lane state (p, d_prev, h_prev) resets to 0.
- Config handshake:
  - cfg_ready=0 in INIT, 1 otherwise.
  - A write occurs on cfg_valid && cfg_ready.
  - sel 0-3 update shadow only.
  - sel 4 copies shadow to active and enters INIT.
- FSM states:
  - INIT: clear all lane state for one cycle; y registered = x; next state LOAD.
  - LOAD: y registered = x (bypass); en=1 goes to RUN.
  - RUN: en=1 advances every lane each cycle; en=0 goes to HOLD.
  - HOLD: lane state frozen; y registered = x; en=1 goes to RUN.
  - A commit in any non-INIT state wins over the en transition and goes to INIT.
  - Illegal encodings go to INIT.
- Per-lane arithmetic, RUN with en=1:
  - d = x - p, DATA_W+1 bits.
  - acc = b0*d + b1*d_prev + a1*h_prev + 2^(FRAC_W-1), full precision.
  - h = sat_{DATA_W+1}(acc >>> FRAC_W).
  - y = sat_{DATA_W}(h + p).
  - Register updates: d_prev<=d, h_prev<=h.
  - If lpf_shift != 0: p <= p + ((x - p) >>> lpf_shift). If lpf_shift == 0: p is held at 0.
- Latency: y is registered, 1 cycle from x in every state.
- Pass-through lanes: y = x delayed 1 cycle in all states.
- Saturation clamps to +2^(W-1)-1 / -2^(W-1); there is no wrap-around anywhere.
- Reset asserted mid-load discards all shadow writes.

Optional Feature:
PEDESTAL_SAT_STATUS_EN:
- Defined: adds output sat_flags [NUM_AFE-1:0]. Bit a is set sticky when any lane of AFE a saturates the y or h stage in RUN. All bits clear on reset or commit.
- Undefined: port and logic are absent; saturation is still applied.

Decomposition:
Package pedestal_filter_pkg holds:
- state enum;
- cfg_sel constants;
- coefficient struct {b0,b1,a1,lpf_shift};
- parametrised saturate function.
Sub-module pedestal_iir_lane: one filtered lane, instantiated NUM_AFE*NUM_CH times by generate. The top module owns the FSM, shadow/active registers, pass-through lanes and status.

Test Plan:
- Reset, release, en=1, lane0 x=1000 held -> y lane0=1000 one cycle later (identity defaults); busy 1 then 0.
- Write b0=16384, commit, en=1, x=1000 -> y=500 on all filtered lanes; pass-through lane outputs 1000.
- Write b0=32768, b1=-32768, a1=0, commit; step x from 0 to 1000 -> y=1000, then 0 on every following cycle.
- Write b0=131071, commit, x=30000 -> y=32767; with PEDESTAL_SAT_STATUS_EN defined, sat_flags[0]=1 until the next commit.
- In RUN drop en for 3 cycles while x changes -> y=x (1-cycle delay), h_prev/p unchanged; re-raise en -> filtering resumes from the frozen state.
- Write b0=0 into shadow, assert reset before commit -> after reset, x=1000 still gives y=1000.

Source files
------------

// File: rtl/pedestal_filter_pkg.sv
// Shared types for pedestal_recovery_filter_bank: FSM states, config selectors,
// coefficient set and a width-parametrised saturation helper.
package pedestal_filter_pkg;

  // Coefficient fields are held sign-extended to this width so that any COEF_W up to it fits
  localparam int unsigned COEF_MAX_W = 32;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_HOLD = 3'd3
  } state_t;

  localparam logic [2:0] SEL_B0     = 3'd0;
  localparam logic [2:0] SEL_B1     = 3'd1;
  localparam logic [2:0] SEL_A1     = 3'd2;
  localparam logic [2:0] SEL_SHIFT  = 3'd3;
  localparam logic [2:0] SEL_COMMIT = 3'd4;

  typedef struct packed {
    logic signed [COEF_MAX_W-1:0] b0;
    logic signed [COEF_MAX_W-1:0] b1;
    logic signed [COEF_MAX_W-1:0] a1;
    logic        [3:0]            lpf_shift;
  } coef_t;

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/pedestal_iir_lane.sv
// One filtered lane: pedestal tracker, first-order IIR high-pass, pedestal re-add
// with saturation. Optional sat strobe under PEDESTAL_SAT_STATUS_EN.
module pedestal_iir_lane
  import pedestal_filter_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     advance,
  input  coef_t                    coef,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] y
`ifdef PEDESTAL_SAT_STATUS_EN
  ,
  output logic                     sat
`endif
);

  localparam int unsigned ACC_W = COEF_MAX_W + DATA_W + 3;
  localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(64'd1 << (FRAC_W - 1));

  logic signed [DATA_W-1:0] p;
  logic signed [DATA_W-1:0] p_next;
  logic signed [DATA_W-1:0] y_next;
  logic signed [DATA_W:0]   d;
  logic signed [DATA_W:0]   d_prev;
  logic signed [DATA_W:0]   h;
  logic signed [DATA_W:0]   h_prev;
  logic signed [63:0]       h_raw;
  logic signed [63:0]       y_raw;

  always_comb begin
    d      = (DATA_W+1)'(x) - (DATA_W+1)'(p);
    h_raw  = 64'((ACC_W'(coef.b0) * ACC_W'(d) + ACC_W'(coef.b1) * ACC_W'(d_prev)
                + ACC_W'(coef.a1) * ACC_W'(h_prev) + ROUND) >>> FRAC_W);
    h      = (DATA_W+1)'(saturate(h_raw, DATA_W + 1));
    y_raw  = 64'(h) + 64'(p);
    y_next = DATA_W'(saturate(y_raw, DATA_W));
    // The estimator step stays between p and x, so truncating back to DATA_W is exact
    p_next = (coef.lpf_shift == 4'd0) ? '0
           : DATA_W'((DATA_W+1)'(p) + (d >>> coef.lpf_shift));
  end

`ifdef PEDESTAL_SAT_STATUS_EN
  assign sat = advance && ((saturate(h_raw, DATA_W + 1) != h_raw) ||
                           (saturate(y_raw, DATA_W) != y_raw));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p      <= '0;
      d_prev <= '0;
      h_prev <= '0;
      y      <= '0;
    end else if (clear) begin
      p      <= '0;
      d_prev <= '0;
      h_prev <= '0;
      y      <= x;
    end else if (advance) begin
      p      <= p_next;
      d_prev <= d;
      h_prev <= h;
      y      <= y_next;
    end else begin
      y      <= x;
    end
  end

endmodule

// File: rtl/pedestal_recovery_filter_bank.sv
// Bank of pedestal-recovery HPF lanes plus per-AFE pass-through lanes, with shadowed
// runtime coefficients. PEDESTAL_SAT_STATUS_EN adds sticky per-AFE sat_flags.
module pedestal_recovery_filter_bank
  import pedestal_filter_pkg::*;
#(
  parameter int unsigned NUM_AFE = 5,
  parameter int unsigned NUM_CH  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned COEF_W  = 18,
  parameter int unsigned FRAC_W  = 15
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  en,
  input  logic [NUM_AFE*(NUM_CH+1)*DATA_W-1:0]  x,
  output logic [NUM_AFE*(NUM_CH+1)*DATA_W-1:0]  y,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  input  logic [2:0]                            cfg_sel,
  input  logic [COEF_W-1:0]                     cfg_data,
  output logic                                  busy
`ifdef PEDESTAL_SAT_STATUS_EN
  ,
  output logic [NUM_AFE-1:0]                    sat_flags
`endif
);

  localparam int unsigned LANES = NUM_AFE * (NUM_CH + 1);
  localparam coef_t COEF_RESET = '{
    b0:        COEF_MAX_W'(64'd1 << FRAC_W),
    b1:        '0,
    a1:        '0,
    lpf_shift: 4'd0
  };

  state_t                   state;
  coef_t                    shadow;
  coef_t                    active;
  logic                     clear;
  logic                     advance;
  logic                     wr;
  logic                     commit;
  logic signed [COEF_MAX_W-1:0] cfg_ext;
  logic signed [DATA_W-1:0] y_lane [LANES];

  assign clear   = (state == ST_INIT);
  assign advance = (state == ST_RUN) && en;
  assign wr      = cfg_valid && cfg_ready;
  assign commit  = wr && (cfg_sel == SEL_COMMIT);
  assign cfg_ext = COEF_MAX_W'(signed'(cfg_data));

`ifdef PEDESTAL_SAT_STATUS_EN
  logic [NUM_AFE*NUM_CH-1:0] lane_sat;
  logic [NUM_AFE-1:0]        afe_sat;

  always_comb begin
    afe_sat = '0;
    for (int unsigned a = 0; a < NUM_AFE; a++) afe_sat[a] = |lane_sat[a*NUM_CH +: NUM_CH];
  end
`endif

  // Commit outranks the en-driven transitions; busy/cfg_ready track the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      busy      <= 1'b1;
      cfg_ready <= 1'b0;
      shadow    <= COEF_RESET;
      active    <= COEF_RESET;
`ifdef PEDESTAL_SAT_STATUS_EN
      sat_flags <= '0;
`endif
    end else if (commit) begin
      active    <= shadow;
      state     <= ST_INIT;
      busy      <= 1'b1;
      cfg_ready <= 1'b0;
`ifdef PEDESTAL_SAT_STATUS_EN
      sat_flags <= '0;
`endif
    end else begin
      if (wr) begin
        case (cfg_sel)
          SEL_B0:    shadow.b0        <= cfg_ext;
          SEL_B1:    shadow.b1        <= cfg_ext;
          SEL_A1:    shadow.a1        <= cfg_ext;
          SEL_SHIFT: shadow.lpf_shift <= cfg_data[3:0];
          default:   ;
        endcase
      end
`ifdef PEDESTAL_SAT_STATUS_EN
      sat_flags <= sat_flags | afe_sat;
`endif
      case (state)
        ST_INIT: begin
          state     <= ST_LOAD;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
        ST_LOAD: if (en) state <= ST_RUN;
        ST_RUN:  if (!en) state <= ST_HOLD;
        ST_HOLD: if (en) state <= ST_RUN;
        default: begin
          state     <= ST_INIT;
          busy      <= 1'b1;
          cfg_ready <= 1'b0;
        end
      endcase
    end
  end

  for (genvar a = 0; a < NUM_AFE; a++) begin : g_afe
    for (genvar c = 0; c <= NUM_CH; c++) begin : g_ch
      localparam int unsigned L = a * (NUM_CH + 1) + c;
      if (c < NUM_CH) begin : g_filt
        pedestal_iir_lane #(
          .DATA_W (DATA_W),
          .FRAC_W (FRAC_W)
        ) u_lane (
          .clk     (clk),
          .reset   (reset),
          .clear   (clear),
          .advance (advance),
          .coef    (active),
          .x       (x[L*DATA_W +: DATA_W]),
          .y       (y_lane[L])
`ifdef PEDESTAL_SAT_STATUS_EN
          ,
          .sat     (lane_sat[a*NUM_CH + c])
`endif
        );
      end else begin : g_pass
        logic signed [DATA_W-1:0] q;
        always_ff @(posedge clk or posedge reset) begin
          if (reset) q <= '0;
          else       q <= x[L*DATA_W +: DATA_W];
        end
        assign y_lane[L] = q;
      end
    end
  end

  always_comb begin
    y = '0;
    for (int unsigned l = 0; l < LANES; l++) y[l*DATA_W +: DATA_W] = y_lane[l];
  end

endmodule

// File: tb/tb_pedestal_recovery_filter_bank.sv
// Directed bench for pedestal_recovery_filter_bank with a behavioural lane/FSM model
// feeding an expected-value queue that is drained one cycle after each stimulus step.
module tb_pedestal_recovery_filter_bank;

  localparam int NUM_AFE = 5;
  localparam int NUM_CH  = 8;
  localparam int DATA_W  = 16;
  localparam int COEF_W  = 18;
  localparam int FRAC_W  = 15;
  localparam int NL      = NUM_AFE * (NUM_CH + 1);

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   en;
  logic [NL*DATA_W-1:0]   x;
  logic [NL*DATA_W-1:0]   y;
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [2:0]             cfg_sel;
  logic [COEF_W-1:0]      cfg_data;
  logic                   busy;
`ifdef PEDESTAL_SAT_STATUS_EN
  logic [NUM_AFE-1:0]     sat_flags;
`endif

  always #5 clk = ~clk;

  pedestal_recovery_filter_bank #(
    .NUM_AFE (NUM_AFE),
    .NUM_CH  (NUM_CH),
    .DATA_W  (DATA_W),
    .COEF_W  (COEF_W),
    .FRAC_W  (FRAC_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .x         (x),
    .y         (y),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .busy      (busy)
`ifdef PEDESTAL_SAT_STATUS_EN
    ,
    .sat_flags (sat_flags)
`endif
  );

  typedef struct {
    int     lane;
    longint val;
  } sb_t;

  sb_t    sbq[$];
  int     vectors = 0;
  int     errors  = 0;

  // model: 0=INIT 1=LOAD 2=RUN 3=HOLD
  int     m_state;
  longint s_b0, s_b1, s_a1, m_b0, m_b1, m_a1;
  int     s_sh, m_sh;
  longint m_p [NL];
  longint m_dp[NL];
  longint m_hp[NL];
  logic [NUM_AFE-1:0] m_sat;

  function automatic longint clamp(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] expv);
    vectors++;
    assert (act === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, act, expv);
    end
  endtask

  function automatic logic signed [31:0] ylane(input int l);
    return 32'($signed(y[l*DATA_W +: DATA_W]));
  endfunction

  task automatic model_reset();
    m_state = 0;
    s_b0 = 64'sd1 <<< FRAC_W; s_b1 = 0; s_a1 = 0; s_sh = 0;
    m_b0 = s_b0; m_b1 = 0; m_a1 = 0; m_sh = 0;
    m_sat = '0;
    for (int l = 0; l < NL; l++) begin
      m_p[l] = 0; m_dp[l] = 0; m_hp[l] = 0;
    end
  endtask

  task automatic tick();
    bit                 adv;
    bit                 wr;
    logic [NUM_AFE-1:0] satc;
    longint             xl, d, hs, h, yv;
    sb_t                e;
    satc = '0;
    adv  = (m_state == 2) && en;
    for (int l = 0; l < NL; l++) begin
      xl = longint'($signed(x[l*DATA_W +: DATA_W]));
      yv = xl;
      if ((l % (NUM_CH + 1)) != NUM_CH) begin
        if (m_state == 0) begin
          m_p[l] = 0; m_dp[l] = 0; m_hp[l] = 0;
        end else if (adv) begin
          d  = xl - m_p[l];
          hs = (m_b0 * d + m_b1 * m_dp[l] + m_a1 * m_hp[l] + (64'sd1 <<< (FRAC_W - 1))) >>> FRAC_W;
          h  = clamp(hs, DATA_W + 1);
          yv = clamp(h + m_p[l], DATA_W);
          if (h != hs || yv != h + m_p[l]) satc[l / (NUM_CH + 1)] = 1'b1;
          m_dp[l] = d;
          m_hp[l] = h;
          m_p[l]  = (m_sh != 0) ? m_p[l] + (d >>> m_sh) : 0;
        end
      end
      e.lane = l;
      e.val  = yv;
      sbq.push_back(e);
    end
    wr = cfg_valid && (m_state != 0);
    if (wr && cfg_sel == 3'd4) begin
      m_b0 = s_b0; m_b1 = s_b1; m_a1 = s_a1; m_sh = s_sh;
      m_state = 0;
      m_sat   = '0;
    end else begin
      if (wr) begin
        case (cfg_sel)
          3'd0: s_b0 = longint'($signed(cfg_data));
          3'd1: s_b1 = longint'($signed(cfg_data));
          3'd2: s_a1 = longint'($signed(cfg_data));
          3'd3: s_sh = int'(cfg_data[3:0]);
          default: ;
        endcase
      end
      case (m_state)
        0: m_state = 1;
        1: if (en) m_state = 2;
        2: if (!en) m_state = 3;
        default: if (en) m_state = 2;
      endcase
      m_sat = m_sat | satc;
    end
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check($sformatf("y[%0d]", e.lane), ylane(e.lane), 32'(e.val));
    end
    check("busy", 32'(busy), 32'(m_state == 0));
    check("cfg_ready", 32'(cfg_ready), 32'(m_state != 0));
`ifdef PEDESTAL_SAT_STATUS_EN
    check("sat_flags", 32'(sat_flags), 32'(m_sat));
`endif
  endtask

  task automatic set_x_all(input int v);
    for (int l = 0; l < NL; l++) x[l*DATA_W +: DATA_W] = DATA_W'(v);
  endtask

  task automatic set_x_rand();
    for (int l = 0; l < NL; l++) x[l*DATA_W +: DATA_W] = DATA_W'(int'($urandom_range(4000)) - 2000);
  endtask

  task automatic cfg_write(input int sel, input int data);
    cfg_valid = 1'b1;
    cfg_sel   = 3'(sel);
    cfg_data  = COEF_W'(data);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    #2;
    for (int l = 0; l < NL; l++) check($sformatf("reset_y[%0d]", l), ylane(l), 32'sd0);
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_cfg_ready", 32'(cfg_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("busy_after_release", 32'(busy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_sel   = '0;
    cfg_data  = '0;
    x         = '0;
    #1;
    apply_reset();

    // identity defaults, distinct per-lane values to expose packing errors
    en = 1'b1;
    for (int l = 0; l < NL; l++) x[l*DATA_W +: DATA_W] = DATA_W'(1000 + 7 * l);
    repeat (4) tick();
    check("identity_lane0", ylane(0), 32'sd1000);

    // b0 = 0.5
    cfg_write(0, 16384);
    cfg_write(4, 0);
    set_x_all(1000);
    repeat (4) tick();
    check("half_gain_lane0", ylane(0), 32'sd500);
    check("passthrough_lane8", ylane(8), 32'sd1000);

    // differentiator: step response 1000 then 0
    cfg_write(0, 32768);
    cfg_write(1, -32768);
    cfg_write(2, 0);
    cfg_write(4, 0);
    set_x_all(0);
    repeat (3) tick();
    set_x_all(1000);
    tick();
    check("step_first_lane0", ylane(0), 32'sd1000);
    tick();
    check("step_second_lane0", ylane(0), 32'sd0);
    tick();

    // saturation, both polarities
    cfg_write(0, 131071);
    cfg_write(4, 0);
    set_x_all(30000);
    repeat (3) tick();
    check("sat_pos_lane0", ylane(0), 32'sd32767);
    set_x_all(-30000);
    tick();
    check("sat_neg_lane0", ylane(0), -32'sd32768);
    tick();

    // IIR feedback with pedestal tracking, then en drop and resume
    cfg_write(0, 32768);
    cfg_write(2, 31130);
    cfg_write(3, 3);
    cfg_write(4, 0);
    repeat (2) tick();
    repeat (6) begin set_x_rand(); tick(); end
    en = 1'b0;
    repeat (3) begin set_x_rand(); tick(); end
    en = 1'b1;
    repeat (6) begin set_x_rand(); tick(); end

    // shadow write discarded by reset before commit
    cfg_write(0, 0);
    apply_reset();
    set_x_all(1000);
    repeat (4) tick();
    check("shadow_discard_lane0", ylane(0), 32'sd1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
